// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix operand loader and the matrix_mul datapath.
package matrix_pkg;

  localparam int DATA_WIDTH_DEF  = 8;
  localparam int MATRIX_SIZE_DEF = 3;

  typedef enum logic [1:0] {
    LOAD_A    = 2'd0,
    LOAD_B    = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } ld_state_e;

  // Row/column index width; a 2x2 matrix still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// Element stream in, operand-store write port and multiply control out.
interface matrix_loader_if
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int MATRIX_SIZE = MATRIX_SIZE_DEF
) ();

  localparam int IDX_W = idx_w(MATRIX_SIZE);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  a_we;
  logic                  b_we;
  logic [IDX_W-1:0]      wr_row;
  logic [IDX_W-1:0]      wr_col;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  start;
  logic                  mm_done;
  logic                  busy;
  logic                  len_err;

  modport master (
    input  in_valid, in_data, in_last, mm_done,
    output in_ready, a_we, b_we, wr_row, wr_col, wr_data, start, busy, len_err
  );

  modport slave (
    output in_valid, in_data, in_last, mm_done,
    input  in_ready, a_we, b_we, wr_row, wr_col, wr_data, start, busy, len_err
  );

endinterface

// File: rtl/rc_counter.sv
// Row-major element position counter over an N x N matrix.
module rc_counter #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] row,
  output logic [W-1:0] col,
  output logic         at_end
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic col_end;

  assign col_end = (col == LAST);
  assign at_end  = col_end && (row == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col_end) begin
        col <= '0;
        row <= (row == LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// Streams A then B row-major into matrix_mul's operand stores, then kicks the multiply.
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int MATRIX_SIZE = MATRIX_SIZE_DEF
) (
  input  logic            clock,
  input  logic            reset,
  matrix_loader_if.master bus
);

  localparam int IDX_W = idx_w(MATRIX_SIZE);

  ld_state_e        state, state_nxt;
  logic             xfer;
  logic             at_end;
  logic             frame_bad;
  logic [IDX_W-1:0] row, col;

  assign bus.in_ready = (state == LOAD_A) || (state == LOAD_B);
  assign xfer         = bus.in_valid && bus.in_ready;

  rc_counter #(.N(MATRIX_SIZE), .W(IDX_W)) u_rc (
    .clock  (clock),
    .reset  (reset),
    .inc    (xfer),
    .row    (row),
    .col    (col),
    .at_end (at_end)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= LOAD_A;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_A:    if (xfer && at_end) state_nxt = LOAD_B;
      LOAD_B:    if (xfer && at_end) state_nxt = START;
      START:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (bus.mm_done) state_nxt = LOAD_A;
      default:   state_nxt = LOAD_A;
    endcase
  end

  // start coincides with the registered write of B[N-1][N-1].
  assign bus.start = (state == START);
  assign bus.busy  = (state == START) || (state == WAIT_DONE);

  // in_last must mark exactly the final B element.
  assign frame_bad = bus.in_last != ((state == LOAD_B) && at_end);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.a_we    <= 1'b0;
      bus.b_we    <= 1'b0;
      bus.wr_row  <= '0;
      bus.wr_col  <= '0;
      bus.wr_data <= '0;
      bus.len_err <= 1'b0;
    end else begin
      bus.a_we <= xfer && (state == LOAD_A);
      bus.b_we <= xfer && (state == LOAD_B);
      if (xfer) begin
        bus.wr_row  <= row;
        bus.wr_col  <= col;
        bus.wr_data <= bus.in_data;
      end
      if (xfer && frame_bad) bus.len_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: expected writes queued at transfer, checked at strobe.
module tb_matrix_loader;
  import matrix_pkg::*;

  localparam int N  = 3;
  localparam int NN = N * N;

  typedef struct {
    bit b;
    int r;
    int c;
    int d;
    bit st;
    bit err;
  } exp_t;

  logic clock;
  logic reset;

  matrix_loader_if #(.DATA_WIDTH(8), .MATRIX_SIZE(N)) bus ();

  matrix_loader #(.DATA_WIDTH(8), .MATRIX_SIZE(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   vectors    = 0;
  int   miscompares = 0;
  int   k          = 0;
  bit   err_m      = 0;
  int   stalls     = 0;
  int   start_cnt  = 0;
  exp_t q[$];
  exp_t me;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest queued element.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.start) start_cnt++;
      if (bus.a_we || bus.b_we) begin
        if (q.size() == 0) chk("spurious_we", 1, 0);
        else begin
          me = q.pop_front();
          chk("b_we",    bus.b_we, me.b);
          chk("a_we",    bus.a_we, !me.b);
          chk("wr_row",  bus.wr_row, me.r);
          chk("wr_col",  bus.wr_col, me.c);
          chk("wr_data", bus.wr_data, me.d);
          chk("start",   bus.start, me.st);
          chk("len_err", bus.len_err, me.err);
        end
      end else if (bus.start) chk("start_no_we", 1, 0);
    end
  end

  task automatic send(input int d, input bit last);
    int   g;
    int   idx;
    exp_t e;
    g = 0;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = d[7:0];
    bus.in_last  = last;
    while (!bus.in_ready && g < 100) begin
      @(negedge clock);
      g++;
    end
    if (!bus.in_ready) begin
      chk("ready_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    stalls += g;
    idx   = k % NN;
    e.b   = (k >= NN);
    e.r   = idx / N;
    e.c   = idx % N;
    e.d   = d;
    e.st  = (k == 2 * NN - 1);
    err_m = err_m | (last != (k == 2 * NN - 1));
    e.err = err_m;
    q.push_back(e);
    k = (k + 1) % (2 * NN);
    @(posedge clock);
  endtask

  task automatic idle();
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic load(input int base, input int last_at, input bit bubble);
    for (int i = 0; i < 2 * NN; i++) begin
      send(base + i, i == last_at);
      if (bubble) idle();
    end
    idle();
  endtask

  // Wait for busy, optionally hold a stalled element, then complete the multiply.
  task automatic mm_finish(input bit hold);
    int g;
    g = 0;
    while (!bus.busy && g < 10) begin
      @(negedge clock);
      g++;
    end
    chk("busy_hi", bus.busy, 1);
    chk("ready_lo", bus.in_ready, 0);
    if (hold) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hEE;
      for (int i = 0; i < 20; i++) begin
        @(negedge clock);
        chk("hold_ready", bus.in_ready, 0);
        chk("hold_busy", bus.busy, 1);
      end
      bus.in_valid = 1'b0;
    end
    @(negedge clock);
    bus.mm_done = 1'b1;
    @(negedge clock);
    bus.mm_done = 1'b0;
    chk("busy_fall", bus.busy, 0);
    chk("ready_rise", bus.in_ready, 1);
    chk("start_cnt", start_cnt, 1);
    chk("q_empty", q.size(), 0);
    start_cnt = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, bus.in_ready, 1);
    chk({tag, "_we"}, {bus.a_we, bus.b_we}, 0);
    chk({tag, "_rowcol"}, {bus.wr_row, bus.wr_col}, 0);
    chk({tag, "_data"}, bus.wr_data, 0);
    chk({tag, "_start"}, bus.start, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_len_err"}, bus.len_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.mm_done  = 1'b0;
    #22;
    chk_reset_vals("rst0");
    @(negedge clock);
    reset = 1'b0;

    // Full-rate load, values 1..18, then stalled element held through the multiply.
    stalls = 0;
    load(1, 2 * NN - 1, 1'b0);
    chk("full_rate_stalls", stalls, 0);
    mm_finish(1'b1);

    // Same stream with a bubble after every element.
    load(1, 2 * NN - 1, 1'b1);
    mm_finish(1'b0);

    // mm_done held high while loading must be ignored.
    bus.mm_done = 1'b1;
    for (int i = 0; i < 2 * NN; i++) begin
      if (i == 2 * NN - 1) bus.mm_done = 1'b0;
      send(40 + i, i == 2 * NN - 1);
      idle();
      if (i < 2 * NN - 1) chk("ld_busy_mmdone", bus.busy, 0);
    end
    mm_finish(1'b0);

    // Framing errors: in_last on element 5, missing on element 18.
    load(100, 4, 1'b0);
    mm_finish(1'b0);
    chk("len_err_sticky", bus.len_err, 1);

    // Reset after 10 transfers abandons the partial load.
    for (int i = 0; i < 10; i++) send(60 + i, 1'b0);
    idle();
    @(negedge clock);
    chk("q_before_rst", q.size(), 0);
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    k     = 0;
    err_m = 0;
    @(negedge clock);
    reset     = 1'b0;
    start_cnt = 0;
    load(200, 2 * NN - 1, 1'b0);
    mm_finish(1'b0);
    chk("len_err_clean", bus.len_err, 0);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Upstream feeder for `matrix_mul`. It accepts a valid/ready stream of matrix elements and writes them row-major into `matrix_mul`'s A and B operand stores: A first, then B. It then pulses `start` and holds off new input until `matrix_mul` reports completion. It replaces hierarchical operand preloading with a real, back-pressured load path.

## Interface
- `DATA_WIDTH`, 8, element width in bits.
- `MATRIX_SIZE`, 3, matrix dimension N (N×N operands), N ≥ 2.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream element valid.
- `in_ready`  out  1  loader can accept an element.
- `in_data`  in  DATA_WIDTH  element value.
- `in_last`  in  1  upstream marks final element of an A+B pair (element 2N²−1).
- `a_we`  out  1  write strobe into A store.
- `b_we`  out  1  write strobe into B store.
- `wr_row`  out  IDX_W  row index, IDX_W = max(1, $clog2(MATRIX_SIZE)).
- `wr_col`  out  IDX_W  column index.
- `wr_data`  out  DATA_WIDTH  element to write.
- `start`  out  1  one-cycle pulse: operands complete, begin multiply.
- `mm_done`  in  1  `matrix_mul` completion level; sampled high means result is ready.
- `busy`  out  1  high from `start` until `mm_done` is seen.
- `len_err`  out  1  sticky framing error.

## Operation
- FSM states: LOAD_A, LOAD_B, START, WAIT_DONE. Reset state is LOAD_A.
- Handshake: an element transfers on a rising edge with `in_valid && in_ready`. `in_ready` = (state is LOAD_A or LOAD_B). It is combinational from state only and never depends on `in_valid`.
- Counters `row`, `col` are IDX_W bits. On each transfer, `col` increments. At `col == N−1`, `col` wraps to 0 and `row` increments. At `row == N−1 && col == N−1`, both wrap to 0.
- LOAD_A → LOAD_B on transfer of A[N−1][N−1]. LOAD_B → START on transfer of B[N−1][N−1].
- START lasts exactly one cycle and asserts `start`, then moves to WAIT_DONE.
- WAIT_DONE → LOAD_A on the first cycle `mm_done` is sampled high. Counters are already 0.
- `in_data` is written unmodified. No arithmetic or width change.
- Framing: `in_last` high on any element other than B[N−1][N−1], or low on B[N−1][N−1], sets `len_err`. The element is still written and the FSM proceeds normally. `len_err` clears only on reset.
- `mm_done` is ignored outside WAIT_DONE. `in_valid` is ignored when `in_ready` is low; no data is lost, because upstream holds the element.

## Timing
- Reset values: `in_ready`=1 (LOAD_A), `a_we`=`b_we`=0, `wr_row`=`wr_col`=0, `wr_data`=0, `start`=0, `busy`=0, `len_err`=0. Counters are 0.
- Write outputs are registered. A transfer at edge t drives `a_we`/`b_we` with that element's `wr_row`/`wr_col`/`wr_data` during cycle t→t+1, with 1-cycle latency. Strobes fall the cycle after any non-transfer cycle.
- Final B transfer at edge t: `b_we` is high in cycle t+1 and `start` is high in cycle t+1, coincident with the last write. `matrix_mul` samples both at edge t+2. `busy` rises with `start` and falls in the cycle after `mm_done` is sampled. `in_ready` rises in that same cycle.
- Full-rate loading: 2N² consecutive transfers with no bubbles. N=3 gives 18 cycles.
- Reset mid-load or mid-multiply returns immediately to reset values. Partially loaded operands are abandoned, and the next element goes to A[0][0].

## Structure
- A shared package `matrix_pkg` holds the state enum, the IDX_W function, and defaults for DATA_WIDTH and MATRIX_SIZE, shared with `matrix_mul`.
- One sub-module: `rc_counter`, a row/column counter with `inc`, wrap-at-N, and `at_end` output, instanced once.
- FSM and output registers live in `matrix_loader`.

## Test plan
- Reset, then stream 18 elements 1..18 back-to-back, `in_last` on the 18th → `a_we` writes A[r][c] = 3r+c+1, `b_we` writes B[r][c] = 3r+c+10, `start` is a single pulse in the cycle of B[2][2]'s write, `len_err`=0.
- Same stream with `in_valid` low every other cycle → identical writes, and 0 strobes in bubble cycles.
- After `start`, hold `in_valid`=1 and keep `mm_done`=0 for 20 cycles → `in_ready`=0 and no writes; raise `mm_done` → `busy` falls, next element is written to A[0][0].
- `in_last` on element 5, and low on element 18 → `len_err`=1 after element 5, all 18 writes still occur, `start` still pulses.
- Assert reset after 10 transfers → outputs return to reset values; a new 18-element load writes A[0][0] first.
- `mm_done` held high during LOAD_A/LOAD_B → ignored, no state change, `busy`=0.
